// File: rtl/pcie_dllp_rx.sv
// Receive-side DLLP consumer: CRC16 check, ACK/NAK sequence tracking and VC0 FC init.
// Two-stage pipeline: input register, then decode into registered outputs.
//
// state    | meaning
// FC_INIT1 | collecting InitFC1 (or InitFC2) for P, NP and Cpl
// FC_INIT2 | FI1 set, waiting for InitFC2 or UpdateFC
// FC_DONE  | DL_Active permitted, UpdateFC forwarded to the credit gate
module pcie_dllp_rx #(
  parameter int SEQ_BITS = 12,
  parameter logic [2:0] VC_ID = 3'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dl_inactive_i,
  input  logic                dllp_valid_i,
  input  logic [63:0]         dllp_data_i,
  input  logic [SEQ_BITS-1:0] next_tx_seq_i,
  output logic                ack_o,
  output logic                nak_o,
  output logic [SEQ_BITS-1:0] acknak_seq_o,
  output logic [SEQ_BITS-1:0] ackd_seq_o,
  output logic                purge_o,
  output logic                fc_valid_o,
  output logic [1:0]          fc_kind_o,
  output logic                fc_init_o,
  output logic [7:0]          hdr_fc_o,
  output logic [11:0]         data_fc_o,
  output logic                fi1_o,
  output logic                dl_up_o,
  output logic                crc_err_o,
  output logic                prot_err_o
);

  typedef enum logic [1:0] {FC_INIT1, FC_INIT2, FC_DONE} fc_state_t;

  fc_state_t           state;
  logic [2:0]          flags;
  logic                s1_valid;
  logic [47:0]         s1_data;
  logic [SEQ_BITS-1:0] s1_next;

  logic                unused_zeros;
  assign unused_zeros = ^dllp_data_i[63:48];

  // LFSR runs LSB-first over type, bytes 1..3; result is inverted and bit-reversed per byte.
  function automatic logic [15:0] dllp_crc(input logic [31:0] d);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h100B;
    end
    for (int j = 0; j < 8; j++) begin
      r[j]     = ~c[15-j];
      r[8 + j] = ~c[7-j];
    end
    return r;
  endfunction

  logic [7:0]          typ;
  logic                crc_ok;
  logic                is_ack, is_nak, is_fc_type, is_init1, is_init2, is_upd;
  logic [1:0]          kind;
  logic [SEQ_BITS-1:0] seq_num, last_seq, dist_s, dist_a;
  logic [7:0]          hdr_val;
  logic [11:0]         data_val;
  logic                seq_bad;

  assign typ        = s1_data[7:0];
  assign crc_ok     = (dllp_crc(s1_data[31:0]) == s1_data[47:32]);
  assign is_ack     = (typ == 8'h00);
  assign is_nak     = (typ == 8'h10);
  assign kind       = typ[5:4];
  assign is_fc_type = (typ[3] == 1'b0) && (typ[2:0] == VC_ID) && (kind != 2'b11);
  assign is_init1   = is_fc_type && (typ[7:6] == 2'b01);
  assign is_init2   = is_fc_type && (typ[7:6] == 2'b11);
  assign is_upd     = is_fc_type && (typ[7:6] == 2'b10);
  assign seq_num    = SEQ_BITS'({s1_data[19:16], s1_data[31:24]});
  assign hdr_val    = {s1_data[13:8], s1_data[23:22]};
  assign data_val   = {s1_data[19:16], s1_data[31:24]};
  // Distances back from the last transmitted sequence number, modulo 2^SEQ_BITS.
  assign last_seq   = s1_next - SEQ_BITS'(1);
  assign dist_s     = last_seq - seq_num;
  assign dist_a     = last_seq - ackd_seq_o;
  assign seq_bad    = dist_s > dist_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FC_INIT1;
      flags        <= '0;
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      s1_next      <= '0;
      ack_o        <= 1'b0;
      nak_o        <= 1'b0;
      acknak_seq_o <= '0;
      ackd_seq_o   <= '1;
      purge_o      <= 1'b0;
      fc_valid_o   <= 1'b0;
      fc_kind_o    <= '0;
      fc_init_o    <= 1'b0;
      hdr_fc_o     <= '0;
      data_fc_o    <= '0;
      fi1_o        <= 1'b0;
      dl_up_o      <= 1'b0;
      crc_err_o    <= 1'b0;
      prot_err_o   <= 1'b0;
    end else if (dl_inactive_i) begin
      state      <= FC_INIT1;
      flags      <= '0;
      s1_valid   <= 1'b0;
      ack_o      <= 1'b0;
      nak_o      <= 1'b0;
      ackd_seq_o <= '1;
      purge_o    <= 1'b0;
      fc_valid_o <= 1'b0;
      fi1_o      <= 1'b0;
      dl_up_o    <= 1'b0;
      crc_err_o  <= 1'b0;
      prot_err_o <= 1'b0;
    end else begin
      s1_valid   <= dllp_valid_i;
      s1_data    <= dllp_data_i[47:0];
      s1_next    <= next_tx_seq_i;
      ack_o      <= 1'b0;
      nak_o      <= 1'b0;
      purge_o    <= 1'b0;
      fc_valid_o <= 1'b0;
      crc_err_o  <= 1'b0;
      prot_err_o <= 1'b0;
      if (s1_valid) begin
        if (!crc_ok) begin
          crc_err_o <= 1'b1;
        end else if (is_ack || is_nak) begin
          if (seq_bad) begin
            prot_err_o <= 1'b1;
          end else begin
            ack_o        <= is_ack;
            nak_o        <= is_nak;
            acknak_seq_o <= seq_num;
            if (seq_num != ackd_seq_o) begin
              ackd_seq_o <= seq_num;
              purge_o    <= 1'b1;
            end
          end
        end else begin
          case (state)
            FC_INIT1: begin
              if (is_init1 || is_init2) begin
                fc_valid_o <= 1'b1;
                fc_init_o  <= 1'b1;
                fc_kind_o  <= kind;
                hdr_fc_o   <= hdr_val;
                data_fc_o  <= data_val;
                flags      <= flags | (3'b001 << kind);
              end
            end
            FC_INIT2: begin
              if (is_init1 || is_init2 || is_upd) begin
                fc_valid_o <= 1'b1;
                fc_init_o  <= !is_upd;
                fc_kind_o  <= kind;
                hdr_fc_o   <= hdr_val;
                data_fc_o  <= data_val;
              end
              if (is_init2 || is_upd) begin
                dl_up_o <= 1'b1;
                state   <= FC_DONE;
              end
            end
            FC_DONE: begin
              if (is_upd) begin
                fc_valid_o <= 1'b1;
                fc_init_o  <= 1'b0;
                fc_kind_o  <= kind;
                hdr_fc_o   <= hdr_val;
                data_fc_o  <= data_val;
              end
            end
            default: state <= FC_INIT1;
          endcase
        end
      end
      // FI1 follows one cycle after the last kind's flag lands.
      if (state == FC_INIT1 && (&flags)) begin
        fi1_o <= 1'b1;
        state <= FC_INIT2;
      end
    end
  end

endmodule

// File: tb/tb_pcie_dllp_rx.sv
// Directed bench for pcie_dllp_rx: a vector table applied one DLLP at a time,
// then hand sequences for flush, back-to-back FC init and async reset.
module tb_pcie_dllp_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dl_inactive;
  logic        dllp_valid;
  logic [63:0] dllp_data;
  logic [11:0] next_tx_seq;
  logic        ack, nak, purge, fc_valid, fc_init, fi1, dl_up, crc_err, prot_err;
  logic [11:0] acknak_seq, ackd_seq, data_fc;
  logic [1:0]  fc_kind;
  logic [7:0]  hdr_fc;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pcie_dllp_rx #(.SEQ_BITS(12), .VC_ID(3'd0)) dut (
    .clk(clk), .rst_n(rst_n), .dl_inactive_i(dl_inactive),
    .dllp_valid_i(dllp_valid), .dllp_data_i(dllp_data), .next_tx_seq_i(next_tx_seq),
    .ack_o(ack), .nak_o(nak), .acknak_seq_o(acknak_seq), .ackd_seq_o(ackd_seq),
    .purge_o(purge), .fc_valid_o(fc_valid), .fc_kind_o(fc_kind), .fc_init_o(fc_init),
    .hdr_fc_o(hdr_fc), .data_fc_o(data_fc), .fi1_o(fi1), .dl_up_o(dl_up),
    .crc_err_o(crc_err), .prot_err_o(prot_err)
  );

  typedef struct {
    logic [7:0]  typ;
    logic [23:0] body;
    logic        bad;
    logic [15:0] pad;
    logic [11:0] nxt;
    logic        e_ack, e_nak;
    logic [11:0] e_seq, e_ackd;
    logic        e_purge, e_fcv;
    logic [1:0]  e_kind;
    logic        e_init;
    logic [7:0]  e_hdr;
    logic [11:0] e_dfc;
    logic        e_fi1, e_up, e_crce, e_prote;
  } vec_t;

  vec_t vecs[16];

  // Reference CRC: shift the 32 header bits in LSB-first order, then map to bytes 4/5.
  function automatic logic [15:0] ref_crc(input logic [7:0] t, input logic [23:0] body);
    logic [31:0] w;
    logic [15:0] lfsr;
    logic [15:0] f;
    logic        top;
    w    = {body, t};
    lfsr = 16'hFFFF;
    for (int k = 0; k < 32; k++) begin
      top  = lfsr[15];
      lfsr = lfsr << 1;
      if (top != w[k]) lfsr = lfsr ^ 16'h100B;
    end
    for (int b = 0; b < 8; b++) begin
      f[b]   = !lfsr[15 - b];
      f[b+8] = !lfsr[7 - b];
    end
    return f;
  endfunction

  function automatic logic [23:0] ack_body(input logic [11:0] s);
    return {s[7:0], 4'h0, s[11:8], 8'h00};
  endfunction

  function automatic logic [23:0] fc_body(input logic [7:0] h, input logic [11:0] d);
    return {d[7:0], h[1:0], 2'b00, d[11:8], 2'b00, h[7:2]};
  endfunction

  function automatic vec_t mk(
    input logic [7:0] typ, input logic [23:0] body, input logic bad, input logic [15:0] pad,
    input logic [11:0] nxt, input logic e_ack, input logic e_nak, input logic [11:0] e_seq,
    input logic [11:0] e_ackd, input logic e_purge, input logic e_fcv, input logic [1:0] e_kind,
    input logic e_init, input logic [7:0] e_hdr, input logic [11:0] e_dfc,
    input logic e_fi1, input logic e_up, input logic e_crce, input logic e_prote);
    vec_t v;
    v.typ = typ; v.body = body; v.bad = bad; v.pad = pad; v.nxt = nxt;
    v.e_ack = e_ack; v.e_nak = e_nak; v.e_seq = e_seq; v.e_ackd = e_ackd;
    v.e_purge = e_purge; v.e_fcv = e_fcv; v.e_kind = e_kind; v.e_init = e_init;
    v.e_hdr = e_hdr; v.e_dfc = e_dfc; v.e_fi1 = e_fi1; v.e_up = e_up;
    v.e_crce = e_crce; v.e_prote = e_prote;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  task automatic drive(input logic [7:0] t, input logic [23:0] body, input logic bad,
                       input logic [15:0] pad, input logic [11:0] nxt);
    dllp_valid  = 1'b1;
    dllp_data   = {pad, ref_crc(t, body) ^ {15'd0, bad}, body, t};
    next_tx_seq = nxt;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    drive(v.typ, v.body, v.bad, v.pad, v.nxt);
    @(negedge clk);
    dllp_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d pulses{ack,nak,purge,fcv,crce,prote}", idx),
        {26'd0, ack, nak, purge, fc_valid, crc_err, prot_err},
        {26'd0, v.e_ack, v.e_nak, v.e_purge, v.e_fcv, v.e_crce, v.e_prote});
    chk($sformatf("v%0d ackd_seq", idx), {20'd0, ackd_seq}, {20'd0, v.e_ackd});
    chk($sformatf("v%0d fi1/dl_up", idx), {30'd0, fi1, dl_up}, {30'd0, v.e_fi1, v.e_up});
    if (v.e_ack || v.e_nak)
      chk($sformatf("v%0d acknak_seq", idx), {20'd0, acknak_seq}, {20'd0, v.e_seq});
    if (v.e_fcv)
      chk($sformatf("v%0d fc{kind,init,hdr,data}", idx),
          {9'd0, fc_kind, fc_init, hdr_fc, data_fc},
          {9'd0, v.e_kind, v.e_init, v.e_hdr, v.e_dfc});
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    dl_inactive = 1'b0;
    dllp_valid  = 1'b0;
    dllp_data   = '0;
    next_tx_seq = '0;

    //             typ    body                    bad   pad      nxt     ack nak seq     ackd    prg fcv kd    ini hdr    dfc      fi1 up  crc prt
    vecs[0]  = mk(8'h31, 24'h000000,              1'b0, 16'h0,   12'h000, 0, 0, 12'h000, 12'hFFF, 0, 0, 2'd0, 0, 8'h00, 12'h000, 0, 0, 0, 0);
    vecs[1]  = mk(8'h40, fc_body(8'h40, 12'h200), 1'b0, 16'h0,   12'h000, 0, 0, 12'h000, 12'hFFF, 0, 1, 2'd0, 1, 8'h40, 12'h200, 0, 0, 0, 0);
    vecs[2]  = mk(8'h50, fc_body(8'h40, 12'h200), 1'b0, 16'h0,   12'h000, 0, 0, 12'h000, 12'hFFF, 0, 1, 2'd1, 1, 8'h40, 12'h200, 0, 0, 0, 0);
    vecs[3]  = mk(8'h60, fc_body(8'h40, 12'h200), 1'b0, 16'h0,   12'h000, 0, 0, 12'h000, 12'hFFF, 0, 1, 2'd2, 1, 8'h40, 12'h200, 0, 0, 0, 0);
    vecs[4]  = mk(8'h80, fc_body(8'h40, 12'h200), 1'b0, 16'h0,   12'h000, 0, 0, 12'h000, 12'hFFF, 0, 1, 2'd0, 0, 8'h40, 12'h200, 1, 1, 0, 0);
    vecs[5]  = mk(8'h00, ack_body(12'h003),       1'b0, 16'h0,   12'h005, 1, 0, 12'h003, 12'h003, 1, 0, 2'd0, 0, 8'h00, 12'h000, 1, 1, 0, 0);
    vecs[6]  = mk(8'h10, ack_body(12'h003),       1'b0, 16'h0,   12'h005, 0, 1, 12'h003, 12'h003, 0, 0, 2'd0, 0, 8'h00, 12'h000, 1, 1, 0, 0);
    vecs[7]  = mk(8'h00, ack_body(12'h007),       1'b0, 16'h0,   12'h005, 0, 0, 12'h000, 12'h003, 0, 0, 2'd0, 0, 8'h00, 12'h000, 1, 1, 0, 1);
    vecs[8]  = mk(8'h00, ack_body(12'hFFE),       1'b0, 16'h0,   12'hFFF, 1, 0, 12'hFFE, 12'hFFE, 1, 0, 2'd0, 0, 8'h00, 12'h000, 1, 1, 0, 0);
    vecs[9]  = mk(8'h00, ack_body(12'h000),       1'b0, 16'h0,   12'h002, 1, 0, 12'h000, 12'h000, 1, 0, 2'd0, 0, 8'h00, 12'h000, 1, 1, 0, 0);
    vecs[10] = mk(8'h00, ack_body(12'h001),       1'b1, 16'h0,   12'h002, 0, 0, 12'h000, 12'h000, 0, 0, 2'd0, 0, 8'h00, 12'h000, 1, 1, 1, 0);
    vecs[11] = mk(8'h41, fc_body(8'h40, 12'h200), 1'b0, 16'h0,   12'h002, 0, 0, 12'h000, 12'h000, 0, 0, 2'd0, 0, 8'h00, 12'h000, 1, 1, 0, 0);
    vecs[12] = mk(8'h81, fc_body(8'h40, 12'h200), 1'b0, 16'h0,   12'h002, 0, 0, 12'h000, 12'h000, 0, 0, 2'd0, 0, 8'h00, 12'h000, 1, 1, 0, 0);
    vecs[13] = mk(8'h90, fc_body(8'h12, 12'h345), 1'b0, 16'hBEEF, 12'h002, 0, 0, 12'h000, 12'h000, 0, 1, 2'd1, 0, 8'h12, 12'h345, 1, 1, 0, 0);
    vecs[14] = mk(8'h31, 24'h000000,              1'b0, 16'h0,   12'h002, 0, 0, 12'h000, 12'h000, 0, 0, 2'd0, 0, 8'h00, 12'h000, 1, 1, 0, 0);
    vecs[15] = mk(8'h10, ack_body(12'h000),       1'b0, 16'h0,   12'h002, 0, 1, 12'h000, 12'h000, 0, 0, 2'd0, 0, 8'h00, 12'h000, 1, 1, 0, 0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset pulses", {26'd0, ack, nak, purge, fc_valid, crc_err, prot_err}, 32'd0);
    chk("reset ackd_seq", {20'd0, ackd_seq}, 32'hFFF);
    chk("reset fi1/dl_up", {30'd0, fi1, dl_up}, 32'd0);

    for (int i = 0; i < 16; i++) run_vec(i);

    // Flush: dl_inactive while an ACK sits in the first stage.
    @(negedge clk);
    drive(8'h00, ack_body(12'h001), 1'b0, 16'h0, 12'h002);
    @(negedge clk);
    dllp_valid  = 1'b0;
    dl_inactive = 1'b1;
    @(negedge clk);
    dl_inactive = 1'b0;
    chk("flush ack", {31'd0, ack}, 32'd0);
    chk("flush ackd_seq", {20'd0, ackd_seq}, 32'hFFF);
    chk("flush fi1/dl_up", {30'd0, fi1, dl_up}, 32'd0);
    @(negedge clk);
    chk("flush late ack", {31'd0, ack}, 32'd0);

    // Back in FC_INIT1, so UpdateFC is dropped.
    drive(8'h80, fc_body(8'h40, 12'h200), 1'b0, 16'h0, 12'h002);
    @(negedge clk);
    dllp_valid = 1'b0;
    @(negedge clk);
    chk("init1 drops update", {31'd0, fc_valid}, 32'd0);

    // Back-to-back InitFC1 P/NP/Cpl.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2 && i <= 4) begin
        chk($sformatf("b2b fcv%0d", i - 2), {31'd0, fc_valid}, 32'd1);
        chk($sformatf("b2b fc%0d{kind,init,hdr,data}", i - 2),
            {9'd0, fc_kind, fc_init, hdr_fc, data_fc},
            {9'd0, 2'(i - 2), 1'b1, 8'h40, 12'h200});
        chk($sformatf("b2b fi1 low %0d", i - 2), {31'd0, fi1}, 32'd0);
      end
      if (i == 5) begin
        chk("b2b fi1 set", {30'd0, fi1, dl_up}, 32'b10);
        chk("b2b idle fcv", {31'd0, fc_valid}, 32'd0);
      end
      if (i < 3) drive(8'h40 + 8'(i * 16), fc_body(8'h40, 12'h200), 1'b0, 16'h0, 12'h002);
      else dllp_valid = 1'b0;
    end

    // InitFC2 NP in FC_INIT2 brings the link up.
    @(negedge clk);
    drive(8'hD0, fc_body(8'h08, 12'h080), 1'b0, 16'h0, 12'h002);
    @(negedge clk);
    dllp_valid = 1'b0;
    @(negedge clk);
    chk("initfc2 dl_up", {31'd0, dl_up}, 32'd1);
    chk("initfc2 fc{v,kind,init,hdr,data}", {8'd0, fc_valid, fc_kind, fc_init, hdr_fc, data_fc},
        {8'd0, 1'b1, 2'd1, 1'b1, 8'h08, 12'h080});

    // Asynchronous reset in the middle of a transfer.
    drive(8'h00, ack_body(12'h001), 1'b0, 16'h0, 12'h002);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst state", {18'd0, ackd_seq, fi1, dl_up}, {18'd0, 12'hFFF, 1'b0, 1'b0});
    dllp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("async rst no ack", {31'd0, ack}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_dllp_rx.md
Name: pcie_dllp_rx

Overview:
Receive-side DLLP consumer in the PCIe Data Link Layer, directly downstream of the PHY DLLP extractor. It accepts one 8-byte DLLP word per cycle in the team's packed DLLP layout and checks its CRC16. It decodes ACK/NAK, NOP, InitFC1/InitFC2 and UpdateFC for VC0, and maintains ACKD_SEQ and the VC0 flow-control-init state machine. Its outputs drive the TLP replay buffer and the TX credit gate.

Parameters:
SEQ_BITS, 12, width of sequence numbers (NEXT_TRANSMIT_SEQ, ACKD_SEQ, AckNak_Seq_Num)
VC_ID, 0, the only VC whose FC DLLPs are accepted; FC DLLPs for any other VC are dropped

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
dl_inactive_i  in  1  link in DL_Inactive; synchronous re-init of all state
dllp_valid_i  in  1  DLLP word valid; no backpressure, one DLLP per asserted cycle
dllp_data_i  in  64  [7:0] type, [31:8] bytes 1-3, [47:32] crc16, [63:48] zeros
next_tx_seq_i  in  12  NEXT_TRANSMIT_SEQ from the TLP transmitter
ack_o  out  1  valid ACK accepted (1-cycle pulse)
nak_o  out  1  valid NAK accepted (1-cycle pulse), i.e. replay request
acknak_seq_o  out  12  AckNak_Seq_Num of the current ack_o/nak_o
ackd_seq_o  out  12  ACKD_SEQ register
purge_o  out  1  ACKD_SEQ advanced this cycle; purge replay buffer up to ackd_seq_o
fc_valid_o  out  1  accepted FC DLLP (1-cycle pulse)
fc_kind_o  out  2  00 P, 01 NP, 10 Cpl
fc_init_o  out  1  with fc_valid_o: 1 = InitFC1/2, 0 = UpdateFC
hdr_fc_o  out  8  HdrFC {hdrFC_h, hdrFC_l}
data_fc_o  out  12  DataFC {dataFC_h, dataFC_l}
fi1_o  out  1  FC_INIT1 complete
dl_up_o  out  1  FC_INIT2 complete (DL_Active permitted)
crc_err_o  out  1  bad-CRC DLLP dropped (pulse)
prot_err_o  out  1  DLLP protocol error: AckNak_Seq_Num out of range (pulse)

Behaviour:
- Reset (rst_n low) and dl_inactive_i: all pulses 0; ackd_seq_o = FFFh; fi1_o = 0; dl_up_o = 0; FSM = FC_INIT1; pipeline valids cleared. dl_inactive_i takes priority over a simultaneous valid DLLP.
- Pipeline: S1 registers the input. S2 computes CRC16 and decodes. Outputs are registered. Latency is 2 cycles from dllp_valid_i to any output pulse. Back-to-back DLLPs run at full rate.
- CRC16: PCIe DLLP CRC, polynomial 100Bh, seed FFFFh, over bytes type, 1, 2, 3 in order, LSB first per byte. The result is complemented and bit-reversed per byte per PCIe mapping. A mismatch gives crc_err_o and the DLLP is dropped with no other side effect. The zeros field is ignored.
- Types, per the PCIe encodings: ACK 00h, NAK 10h, NOP 31h (consumed silently).
  - InitFC1 P/NP/Cpl: 0100_0vvv, 0101_0vvv, 0110_0vvv.
  - InitFC2: 1100/1101/1110_0vvv.
  - UpdateFC: 1000/1001/1010_0vvv.
  - vvv != VC_ID, or any other type, is dropped silently.
  - Scale fields are ignored (scaled FC is unsupported).
- ACK/NAK check, mod 4096: let L = next_tx_seq_i - 1 and s = AckNak_Seq_Num.
  - If (L - s) > (L - ackd_seq), assert prot_err_o; no ack/nak pulse, no state change.
  - Otherwise pulse ack_o or nak_o with acknak_seq_o = s.
  - If s != ackd_seq, then ackd_seq <= s and purge_o pulses in the same cycle as ack_o/nak_o.
  - A NAK with s == ackd_seq is a legal pure replay request.
- FC FSM: FC_INIT1 -> FC_INIT2 -> DONE.
  - FC_INIT1: set a per-kind flag on each InitFC1 (InitFC2 also counts). fc_valid_o is asserted with fc_init_o = 1. When all three flags are set, fi1_o <= 1 and the FSM moves to FC_INIT2. The transition registers in the cycle after the third flag's output pulse.
  - FC_INIT2: any InitFC2 or UpdateFC gives dl_up_o <= 1 and the FSM moves to DONE.
  - DONE: UpdateFC produces fc_valid_o with fc_init_o = 0. InitFC1/InitFC2 are dropped.
  - UpdateFC received in FC_INIT1 is dropped.
- ACK/NAK is processed in every FSM state.
- rst_n can assert at any time. dl_inactive_i asserted mid-pipeline flushes any in-flight DLLP (no output pulse).

Test Plan:
- Reset, then an idle cycle -> ackd_seq_o = FFFh, fi1_o = 0, dl_up_o = 0, all pulses 0.
- InitFC1-P, -NP, -Cpl for VC0 (HdrFC = 40h, DataFC = 200h) sent back to back -> three fc_valid_o pulses 2 cycles later with fc_kind 0/1/2, hdr_fc_o = 40h, data_fc_o = 200h. Then fi1_o = 1. A following UpdateFC-P gives dl_up_o = 1.
- next_tx_seq_i = 005h, ACK seq 003h -> ack_o, acknak_seq_o = 003h, purge_o, ackd_seq_o = 003h. Then NAK seq 003h -> nak_o, no purge_o.
- next_tx_seq_i = 005h, ackd_seq = 003h, ACK seq 007h -> prot_err_o only, ackd_seq_o unchanged. Wrap case: ackd = FFEh, next_tx_seq_i = 002h, ACK 000h -> accepted, ackd_seq_o = 000h.
- Valid ACK with crc16 bit 0 flipped -> crc_err_o only. InitFC1-P for VC 1 -> no output.
- dl_inactive_i asserted 1 cycle after a valid ACK -> no ack_o, ackd_seq_o = FFFh, FSM back to FC_INIT1.
